// File: rtl/pack_unbuild_pkg.sv
//------------------------------------------------------------------------------
// pack_unbuild_pkg : shared framing constants and deframer state encoding
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pack_unbuild_pkg;

    localparam logic [7:0] SYNC_FF       = 8'hFF;
    localparam logic [7:0] SYNC_END      = 8'h7F;
    localparam int         SYNC_FF_LEN   = 3;
    localparam int         PKT_BYTES_DEF = 16;
    localparam int         CNTW_DEF      = 16;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        EXPECT = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/pack_unbuild_hold.sv
//------------------------------------------------------------------------------
// pkt_hold : packet holding register with valid/ready, toggle strobe and
//            overflow detection for packets arriving while still occupied
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pkt_hold #(
    parameter int PW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [PW-1:0] data_i,
    input  logic          ready_i,
    output logic [PW-1:0] data_o,
    output logic          valid_o,
    output logic          avail_o,
    output logic          accept_o,
    output logic          drop_o,
    output logic          overf_o
);

    logic [PW-1:0] data_q;
    logic          valid_q;
    logic          avail_q;
    logic          overf_q;
    logic          w_accept;

    // A slot being drained on this same edge can take the new packet.
    assign w_accept = load_i && (!valid_q || ready_i);
    assign accept_o = w_accept;
    assign drop_o   = load_i && !w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            avail_q <= 1'b0;
            overf_q <= 1'b0;
        end else begin
            overf_q <= load_i && !w_accept;
            if (w_accept) begin
                data_q  <= data_i;
                valid_q <= 1'b1;
                avail_q <= ~avail_q;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign avail_o = avail_q;
    assign overf_o = overf_q;

endmodule

`default_nettype wire

// File: rtl/pack_unbuild.sv
//------------------------------------------------------------------------------
// pack_unbuild : framed byte stream deframer (FF FF FF 7F + payload, LSB first)
//                with lock tracking, packet hand-off and saturating statistics
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pack_unbuild
    import pack_unbuild_pkg::*;
#(
    parameter int CNTW      = CNTW_DEF,
    parameter int PKT_BYTES = PKT_BYTES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             DataVal,
    input  logic                   DataReady,
    output logic                   DataNext,
    output logic [8*PKT_BYTES-1:0] Packet,
    output logic                   PkValid,
    input  logic                   PkReady,
    output logic                   PkAvail,
    output logic                   inSync,
    output logic                   SyncErr,
    output logic                   DataOverf,
    output logic [CNTW-1:0]        FrameCount,
    output logic [CNTW-1:0]        ErrCount
);

    localparam int PW  = 8 * PKT_BYTES;
    localparam int BCW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

    state_e          state_q;
    logic [1:0]      ff_cnt_q;
    logic [BCW-1:0]  byte_cnt_q;
    logic [1:0]      idx_q;
    logic [PW-9:0]   sh_q;
    logic            in_sync_q;
    logic            sync_err_q;
    logic            data_next_q;
    logic [CNTW-1:0] frame_cnt_q;
    logic [CNTW-1:0] err_cnt_q;

    logic            w_done;
    logic            w_mismatch;
    logic            w_accept;
    logic            w_drop;
    logic [7:0]      w_exp_byte;
    logic [PW-1:0]   w_pkt;
    logic [CNTW:0]   w_err_sum;

    assign w_done     = DataReady && (state_q == DATA) &&
                        (byte_cnt_q == BCW'(PKT_BYTES - 1));
    assign w_exp_byte = (idx_q == 2'(SYNC_FF_LEN)) ? SYNC_END : SYNC_FF;
    assign w_mismatch = DataReady && (state_q == EXPECT) && (DataVal != w_exp_byte);
    assign w_pkt      = {DataVal, sh_q};

    // The extra top bit only sets when the sum passes all-ones, i.e. saturation.
    assign w_err_sum  = {1'b0, err_cnt_q} + (CNTW+1)'(w_mismatch) + (CNTW+1)'(w_drop);

    pkt_hold #(
        .PW (PW)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load_i   (w_done),
        .data_i   (w_pkt),
        .ready_i  (PkReady),
        .data_o   (Packet),
        .valid_o  (PkValid),
        .avail_o  (PkAvail),
        .accept_o (w_accept),
        .drop_o   (w_drop),
        .overf_o  (DataOverf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            ff_cnt_q    <= 2'd0;
            byte_cnt_q  <= '0;
            idx_q       <= 2'd0;
            sh_q        <= '0;
            in_sync_q   <= 1'b0;
            sync_err_q  <= 1'b0;
            data_next_q <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            data_next_q <= 1'b1;
            sync_err_q  <= w_mismatch;

            if (w_accept) begin
                in_sync_q <= 1'b1;
            end else if (w_mismatch) begin
                in_sync_q <= 1'b0;
            end

            if (w_accept && (frame_cnt_q != '1)) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
            err_cnt_q <= w_err_sum[CNTW] ? '1 : w_err_sum[CNTW-1:0];

            if (DataReady) begin
                case (state_q)
                    HUNT: begin
                        if (DataVal == SYNC_FF) begin
                            if (ff_cnt_q != 2'(SYNC_FF_LEN)) begin
                                ff_cnt_q <= ff_cnt_q + 2'd1;
                            end
                        end else if ((DataVal == SYNC_END) &&
                                     (ff_cnt_q == 2'(SYNC_FF_LEN))) begin
                            state_q    <= DATA;
                            byte_cnt_q <= '0;
                            ff_cnt_q   <= 2'd0;
                        end else begin
                            ff_cnt_q <= 2'd0;
                        end
                    end
                    DATA: begin
                        sh_q <= {DataVal, sh_q[PW-9:8]};
                        if (w_done) begin
                            state_q <= EXPECT;
                            idx_q   <= 2'd0;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end
                    EXPECT: begin
                        if (w_mismatch) begin
                            // An FF where 7F was due is a 4th FF: keep a full run.
                            state_q <= HUNT;
                            if (DataVal == SYNC_FF) begin
                                ff_cnt_q <= (idx_q == 2'(SYNC_FF_LEN)) ? 2'(SYNC_FF_LEN) : 2'd1;
                            end else begin
                                ff_cnt_q <= 2'd0;
                            end
                        end else if (idx_q == 2'(SYNC_FF_LEN)) begin
                            state_q    <= DATA;
                            byte_cnt_q <= '0;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                    end
                endcase
            end
        end
    end

    assign DataNext   = data_next_q;
    assign inSync     = in_sync_q;
    assign SyncErr    = sync_err_q;
    assign FrameCount = frame_cnt_q;
    assign ErrCount   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pack_unbuild.sv
//------------------------------------------------------------------------------
// tb_pack_unbuild : directed scoreboard bench for the pack_unbuild deframer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pack_unbuild;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   DataVal = 8'h00;
    logic         DataReady = 1'b0;
    logic         DataNext;
    logic [127:0] Packet;
    logic         PkValid;
    logic         PkReady = 1'b1;
    logic         PkAvail;
    logic         inSync;
    logic         SyncErr;
    logic         DataOverf;
    logic [15:0]  FrameCount;
    logic [15:0]  ErrCount;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp_q[$];
    int           pres_tot = 0;
    int           serr_tot = 0;
    int           ovf_tot  = 0;
    int           pres_base, serr_base, ovf_base;

    always #5 clk = ~clk;

    pack_unbuild #(
        .CNTW      (16),
        .PKT_BYTES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .DataVal    (DataVal),
        .DataReady  (DataReady),
        .DataNext   (DataNext),
        .Packet     (Packet),
        .PkValid    (PkValid),
        .PkReady    (PkReady),
        .PkAvail    (PkAvail),
        .inSync     (inSync),
        .SyncErr    (SyncErr),
        .DataOverf  (DataOverf),
        .FrameCount (FrameCount),
        .ErrCount   (ErrCount)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Each PkAvail toggle marks a newly presented packet.
    task automatic monitor();
        logic last_avail;
        last_avail = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            serr_tot += int'(SyncErr);
            ovf_tot  += int'(DataOverf);
            if (rst) begin
                last_avail = PkAvail;
            end else if (PkAvail !== last_avail) begin
                last_avail = PkAvail;
                pres_tot++;
                chk("valid_on_present", 128'(PkValid), 128'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_packet", 128'(exp_q.size()), 128'd1);
                end else begin
                    chk("packet", Packet, exp_q.pop_front());
                end
            end
        end
    endtask

    function automatic logic [127:0] make_pkt(input logic [7:0] first);
        logic [127:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            p[8*i +: 8] = first + 8'(i);
        end
        return p;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        DataVal   = b;
        DataReady = 1'b1;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        DataReady = 1'b0;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_sync();
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h7F);
    endtask

    task automatic send_frame(input logic [7:0] first, input bit push);
        if (push) exp_q.push_back(make_pkt(first));
        send_sync();
        for (int i = 0; i < 16; i++) send_byte(first + 8'(i));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        DataReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        pres_base = pres_tot;
        serr_base = serr_tot;
        ovf_base  = ovf_tot;
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_datanext",   128'(DataNext),   128'd0);
        chk("rst_pkvalid",    128'(PkValid),    128'd0);
        chk("rst_pkavail",    128'(PkAvail),    128'd0);
        chk("rst_insync",     128'(inSync),     128'd0);
        chk("rst_framecount", 128'(FrameCount), 128'd0);
        chk("rst_errcount",   128'(ErrCount),   128'd0);
        chk("rst_packet",     Packet,           128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("datanext_after_rst", 128'(DataNext), 128'd1);
        pres_base = pres_tot;
        serr_base = serr_tot;
        ovf_base  = ovf_tot;

        // Clean frame, payload 00..0F
        exp_q.push_back(128'h0F0E0D0C0B0A09080706050403020100);
        send_sync();
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        #1;
        chk("t1_pkvalid_n1", 128'(PkValid), 128'd1);
        chk("t1_pkavail",    128'(PkAvail), 128'd1);
        chk("t1_insync",     128'(inSync),  128'd1);
        chk("t1_framecount", 128'(FrameCount), 128'd1);
        idle(3);
        chk("t1_presented", 128'(pres_tot - pres_base), 128'd1);
        chk("t1_errcount",  128'(ErrCount), 128'd0);
        chk("t1_queue",     128'(exp_q.size()), 128'd0);

        // Back-to-back frames
        do_reset();
        send_frame(8'h00, 1'b1);
        send_frame(8'h10, 1'b1);
        idle(4);
        chk("t2_presented",  128'(pres_tot - pres_base), 128'd2);
        chk("t2_framecount", 128'(FrameCount), 128'd2);
        chk("t2_errcount",   128'(ErrCount), 128'd0);
        chk("t2_syncerr",    128'(serr_tot - serr_base), 128'd0);
        chk("t2_queue",      128'(exp_q.size()), 128'd0);

        // Garbage, a short FF run, then payload containing sync-like bytes
        do_reset();
        exp_q.push_back(128'h7FAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h7F);
        send_sync();
        for (int i = 0; i < 15; i++) send_byte(8'hAA);
        send_byte(8'h7F);
        idle(3);
        chk("t3_presented",  128'(pres_tot - pres_base), 128'd1);
        chk("t3_packet",     Packet, 128'h7FAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA);
        chk("t3_framecount", 128'(FrameCount), 128'd1);
        chk("t3_queue",      128'(exp_q.size()), 128'd0);

        // Broken resync then relock
        do_reset();
        send_frame(8'h00, 1'b1);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h00);
        idle(2);
        chk("t4_syncerr",   128'(serr_tot - serr_base), 128'd1);
        chk("t4_insync_lo", 128'(inSync), 128'd0);
        chk("t4_errcount",  128'(ErrCount), 128'd1);
        send_frame(8'h20, 1'b1);
        idle(3);
        chk("t4_framecount", 128'(FrameCount), 128'd2);
        chk("t4_insync_hi",  128'(inSync), 128'd1);
        chk("t4_errcount2",  128'(ErrCount), 128'd1);
        chk("t4_presented",  128'(pres_tot - pres_base), 128'd2);
        chk("t4_queue",      128'(exp_q.size()), 128'd0);

        // Overflow with consumer stalled
        do_reset();
        PkReady = 1'b0;
        send_frame(8'h40, 1'b1);
        send_frame(8'h50, 1'b0);
        send_frame(8'h60, 1'b0);
        idle(3);
        chk("t5_packet_held", Packet, make_pkt(8'h40));
        chk("t5_pkvalid",     128'(PkValid), 128'd1);
        chk("t5_overf",       128'(ovf_tot - ovf_base), 128'd2);
        chk("t5_errcount",    128'(ErrCount), 128'd2);
        chk("t5_framecount",  128'(FrameCount), 128'd1);
        chk("t5_presented",   128'(pres_tot - pres_base), 128'd1);
        @(negedge clk);
        PkReady = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_pkvalid_clr", 128'(PkValid), 128'd0);

        // Reset in the middle of a frame
        do_reset();
        send_sync();
        for (int i = 0; i < 8; i++) send_byte(8'h80 + 8'(i));
        do_reset();
        send_frame(8'h30, 1'b1);
        idle(3);
        chk("t6_presented",  128'(pres_tot - pres_base), 128'd1);
        chk("t6_framecount", 128'(FrameCount), 128'd1);
        chk("t6_packet",     Packet, make_pkt(8'h30));
        chk("t6_queue",      128'(exp_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
